// File: rtl/hex_display_scheduler_if.sv
// Bus between the HEX display scheduler and its environment.
// master: drives the source values, per-source update strobes and freeze;
//         observes the selected value, selected index, label digit and hold flag.
// slave : the scheduler side.
interface hex_display_scheduler_if #(
  parameter int N_SRC = 3
);
  localparam int SEL_W = $clog2(N_SRC);

  logic [N_SRC-1:0][5:0] value_i;    // source k at bits [6k+5:6k]
  logic [N_SRC-1:0]      upd_i;      // per-source change strobe
  logic                  freeze_i;   // pauses the dwell/hold timer
  logic [5:0]            disp_value; // registered value of selected source
  logic [SEL_W-1:0]      disp_sel;   // selected source index
  logic [6:0]            label_hex;  // active-low 7-seg digit of disp_sel
  logic                  hold_o;     // high while a source is pinned

  modport master (
    output value_i, upd_i, freeze_i,
    input  disp_value, disp_sel, label_hex, hold_o
  );

  modport slave (
    input  value_i, upd_i, freeze_i,
    output disp_value, disp_sel, label_hex, hold_o
  );
endinterface

// File: rtl/hex_display_scheduler.sv
// Time-shares a two-digit decimal HEX readout among N_SRC 6-bit values.
// Rotates through the sources every DWELL cycles; a source that signals an
// update pre-empts the rotation and is pinned for HOLD cycles. A freeze input
// pauses the timer (updates still pre-empt while frozen).
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high
//   bus   - hex_display_scheduler_if.slave (values, strobes, freeze in;
//           selected value, index, label digit, hold flag out)
module hex_display_scheduler #(
  parameter int N_SRC = 3,
  parameter int DWELL = 50_000_000,
  parameter int HOLD  = 100_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  hex_display_scheduler_if.slave   bus
);
  localparam int SEL_W = $clog2(N_SRC);
  localparam int MAXC  = (DWELL > HOLD) ? DWELL : HOLD;
  localparam int TW    = $clog2(MAXC);

  localparam logic [TW-1:0]    DWELL_END = TW'(DWELL - 1);
  localparam logic [TW-1:0]    HOLD_END  = TW'(HOLD - 1);
  localparam logic [SEL_W-1:0] LAST_SRC  = SEL_W'(N_SRC - 1);

  typedef enum logic {ROTATE, HOLD_ST} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [SEL_W-1:0] upd_idx;
  logic [5:0]       disp_value;
  logic [6:0]       label_hex;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Lowest-numbered set strobe wins: scan downward so the last hit is lowest.
  always_comb begin
    upd_idx = '0;
    for (int k = N_SRC - 1; k >= 0; k--)
      if (bus.upd_i[k]) upd_idx = SEL_W'(k);
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    timer_nxt = timer;
    if (bus.upd_i != '0) begin
      // Pre-emption beats expiry and ignores freeze.
      state_nxt = HOLD_ST;
      sel_nxt   = upd_idx;
      timer_nxt = '0;
    end else if (!bus.freeze_i) begin
      case (state)
        ROTATE: begin
          if (timer == DWELL_END) begin
            sel_nxt   = (sel == LAST_SRC) ? '0 : sel + SEL_W'(1);
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
        HOLD_ST: begin
          if (timer == HOLD_END) begin
            state_nxt = ROTATE;  // resume rotation on the pinned source
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
        default: state_nxt = ROTATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ROTATE;
      sel        <= '0;
      timer      <= '0;
      disp_value <= '0;
      label_hex  <= 7'b1000000;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      timer      <= timer_nxt;
      // Display path lags sel by one cycle and tracks live value changes.
      disp_value <= bus.value_i[sel];
      label_hex  <= seg7(4'(sel));
    end
  end

  assign bus.disp_value = disp_value;
  assign bus.label_hex  = label_hex;
  assign bus.disp_sel   = sel;
  assign bus.hold_o     = (state == HOLD_ST);
endmodule
